// File: rtl/y86_pkg.sv
// Shared Y86-64 execute-stage constants: instruction codes, ALU functions,
// branch/move conditions and the condition-code reset value.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_AND  = 4'h2;
   localparam logic [3:0] ALU_XOR  = 4'h3;

   localparam logic [3:0] C_YES    = 4'h0;
   localparam logic [3:0] C_LE     = 4'h1;
   localparam logic [3:0] C_L      = 4'h2;
   localparam logic [3:0] C_E      = 4'h3;
   localparam logic [3:0] C_NE     = 4'h4;
   localparam logic [3:0] C_GE     = 4'h5;
   localparam logic [3:0] C_G      = 4'h6;

   // {ZF, SF, OF}
   localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/y86_alu_core.sv
// 64-bit Y86 ALU: computes result = b op a and the {ZF, SF, OF} flags.
// Unknown function codes yield a zero result and raise fun_err.
module y86_alu_core
   import y86_pkg::*;
(
   input  logic [3:0]  alu_fun,
   input  logic [63:0] alu_a,
   input  logic [63:0] alu_b,
   output logic [63:0] result,
   output logic [2:0]  flags,
   output logic        fun_err
);

   logic [63:0] res_s;
   logic        of_s;

   // Function decode, result and overflow per operation
   always_comb begin
      res_s   = 64'd0;
      of_s    = 1'b0;
      fun_err = 1'b0;
      case (alu_fun)
         ALU_ADD: begin
            res_s = alu_b + alu_a;
            of_s  = (alu_a[63] == alu_b[63]) && (res_s[63] != alu_a[63]);
         end
         ALU_SUB: begin
            res_s = alu_b - alu_a;
            of_s  = (alu_a[63] != alu_b[63]) && (res_s[63] != alu_b[63]);
         end
         ALU_AND: res_s = alu_b & alu_a;
         ALU_XOR: res_s = alu_b ^ alu_a;
         default: begin
            res_s   = 64'd0;
            fun_err = 1'b1;
         end
      endcase
   end

   assign result = res_s;
   assign flags  = {(res_s == 64'd0), res_s[63], of_s};

endmodule

// File: rtl/y86_execute_unit.sv
// Y86-64 execute stage: operand selection, ALU, condition-code register,
// branch/move condition evaluation and data-memory address/enable generation.
module y86_execute_unit
   import y86_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  icode,
   input  logic [3:0]  ifun,
   input  logic [63:0] valC,
   input  logic [63:0] valA,
   input  logic [63:0] valB,
   output logic [63:0] valE,
   output logic [2:0]  cc,
   output logic        cnd,
   output logic [63:0] mem_addr,
   output logic        mem_write,
   output logic        mem_read,
   output logic        alu_err
);

   logic [63:0] alu_a_s;
   logic [63:0] alu_b_s;
   logic [3:0]  alu_fun_s;
   logic [2:0]  flags_s;
   logic [2:0]  cc_r;
   logic        zf_s, sf_s, of_s;

   // Operand and ALU function selection by instruction
   always_comb begin
      alu_a_s = 64'd0;
      alu_b_s = 64'd0;
      case (icode)
         I_RRMOVQ, I_OPQ:             alu_a_s = valA;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a_s = valC;
         I_CALL, I_PUSHQ:             alu_a_s = 64'hFFFF_FFFF_FFFF_FFF8;
         I_RET, I_POPQ:               alu_a_s = 64'd8;
         default:                     alu_a_s = 64'd0;
      endcase
      case (icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
         I_RET, I_PUSHQ, I_POPQ:      alu_b_s = valB;
         default:                     alu_b_s = 64'd0;
      endcase
      if (icode == I_OPQ) begin
         alu_fun_s = ifun;
      end else begin
         alu_fun_s = ALU_ADD;
      end
   end

   y86_alu_core u_alu (
      .alu_fun (alu_fun_s),
      .alu_a   (alu_a_s),
      .alu_b   (alu_b_s),
      .result  (valE),
      .flags   (flags_s),
      .fun_err (alu_err)
   );

   // Condition-code register: reset wins over a simultaneous OPq update
   always_ff @(posedge clk) begin
      if (reset) begin
         cc_r <= CC_RESET;
      end else if ((icode == I_OPQ) && !alu_err) begin
         cc_r <= flags_s;
      end else begin
         cc_r <= cc_r;
      end
   end

   assign cc = cc_r;
   assign {zf_s, sf_s, of_s} = cc_r;

   // Condition outcome from the flags of the previous OPq
   always_comb begin
      cnd = 1'b0;
      case (ifun)
         C_YES:   cnd = 1'b1;
         C_LE:    cnd = (sf_s ^ of_s) | zf_s;
         C_L:     cnd = sf_s ^ of_s;
         C_E:     cnd = zf_s;
         C_NE:    cnd = ~zf_s;
         C_GE:    cnd = ~(sf_s ^ of_s);
         C_G:     cnd = ~(sf_s ^ of_s) & ~zf_s;
         default: cnd = 1'b0;
      endcase
   end

   // Data-memory address and access enables
   always_comb begin
      mem_addr  = 64'd0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      case (icode)
         I_RMMOVQ, I_CALL, I_PUSHQ: begin
            mem_addr  = valE;
            mem_write = 1'b1;
         end
         I_MRMOVQ: begin
            mem_addr = valE;
            mem_read = 1'b1;
         end
         I_RET, I_POPQ: begin
            mem_addr = valA;
            mem_read = 1'b1;
         end
         default: begin
            mem_addr  = 64'd0;
            mem_write = 1'b0;
            mem_read  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_y86_execute_unit.sv
// Scoreboard bench for y86_execute_unit: a reference model pushes expected
// results as each instruction is driven; they are popped and compared.
module tb_y86_execute_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  icode, ifun;
   logic [63:0] valC, valA, valB;
   logic [63:0] valE, mem_addr;
   logic [2:0]  cc;
   logic        cnd, mem_write, mem_read, alu_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0]  ic;
      logic [63:0] vale;
      logic        cnd;
      logic [63:0] addr;
      logic        wr;
      logic        rd;
      logic        err;
      logic [2:0]  cc_next;
   } exp_t;

   exp_t        sb[$];
   logic [2:0]  m_cc;

   y86_execute_unit dut (
      .clk       (clk),
      .reset     (reset),
      .icode     (icode),
      .ifun      (ifun),
      .valC      (valC),
      .valA      (valA),
      .valB      (valB),
      .valE      (valE),
      .cc        (cc),
      .cnd       (cnd),
      .mem_addr  (mem_addr),
      .mem_write (mem_write),
      .mem_read  (mem_read),
      .alu_err   (alu_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Independent reference: overflow via 65-bit sign-extended arithmetic
   function automatic exp_t model(input logic rst, input logic [3:0] ic, input logic [3:0] fn,
                                  input logic [63:0] c, input logic [63:0] a_in,
                                  input logic [63:0] b_in, input logic [2:0] cc_in);
      exp_t e;
      logic [63:0] a, b, r;
      logic [64:0] w;
      logic        of, err, zf, sf, ofl;
      logic [3:0]  f;
      a = 64'd0; b = 64'd0; r = 64'd0; of = 1'b0;
      if (ic == 4'h2 || ic == 4'h6) a = a_in;
      else if (ic == 4'h3 || ic == 4'h4 || ic == 4'h5) a = c;
      else if (ic == 4'h8 || ic == 4'hA) a = -64'sd8;
      else if (ic == 4'h9 || ic == 4'hB) a = 64'd8;
      if (ic >= 4'h4 && ic <= 4'hB && ic != 4'h7) b = b_in;
      f   = (ic == 4'h6) ? fn : 4'h0;
      err = (ic == 4'h6) && (fn > 4'h3);
      if (f == 4'h0) begin
         w = {b[63], b} + {a[63], a}; r = w[63:0]; of = w[64] ^ w[63];
      end else if (f == 4'h1) begin
         w = {b[63], b} - {a[63], a}; r = w[63:0]; of = w[64] ^ w[63];
      end else if (f == 4'h2) r = b & a;
      else if (f == 4'h3) r = b ^ a;
      e.ic   = ic;
      e.vale = r;
      e.err  = err;
      zf = cc_in[2]; sf = cc_in[1]; ofl = cc_in[0];
      case (fn)
         4'h0: e.cnd = 1'b1;
         4'h1: e.cnd = (sf != ofl) || zf;
         4'h2: e.cnd = (sf != ofl);
         4'h3: e.cnd = zf;
         4'h4: e.cnd = !zf;
         4'h5: e.cnd = (sf == ofl);
         4'h6: e.cnd = (sf == ofl) && !zf;
         default: e.cnd = 1'b0;
      endcase
      e.wr   = (ic == 4'h4 || ic == 4'h8 || ic == 4'hA);
      e.rd   = (ic == 4'h5 || ic == 4'h9 || ic == 4'hB);
      e.addr = (ic == 4'h4 || ic == 4'h5 || ic == 4'h8 || ic == 4'hA) ? r :
               (ic == 4'h9 || ic == 4'hB) ? a_in : 64'd0;
      if (rst) e.cc_next = 3'b100;
      else if (ic == 4'h6 && !err) e.cc_next = {(r == 64'd0), r[63], of};
      else e.cc_next = cc_in;
      return e;
   endfunction

   task automatic apply(input logic rst, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] c, input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      reset = rst; icode = ic; ifun = fn; valC = c; valA = a; valB = b;
      sb.push_back(model(rst, ic, fn, c, a, b, m_cc));
      #2;
      if (sb.size() == 0) begin
         check_val("scoreboard_empty", 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         check_val("valE", valE, e.vale);
         check_val("mem_addr", mem_addr, e.addr);
         check_val("mem_write", {63'd0, mem_write}, {63'd0, e.wr});
         check_val("mem_read", {63'd0, mem_read}, {63'd0, e.rd});
         check_val("alu_err", {63'd0, alu_err}, {63'd0, e.err});
         if (e.ic == 4'h2 || e.ic == 4'h7)
            check_val("cnd", {63'd0, cnd}, {63'd0, e.cnd});
         @(posedge clk);
         #1;
         check_val("cc", {61'd0, cc}, {61'd0, e.cc_next});
         m_cc = e.cc_next;
      end
   endtask

   initial begin
      reset = 1'b1; icode = 4'h1; ifun = 4'h0;
      valC = 64'd0; valA = 64'd0; valB = 64'd0;
      repeat (2) @(posedge clk);
      #1;
      check_val("cc_reset", {61'd0, cc}, 64'd4);
      m_cc = 3'b100;

      apply(1'b0, 4'h6, 4'h0, 64'd0, 64'd5, 64'd7);
      check_val("add_vale_lit", valE, 64'd12);
      apply(1'b0, 4'h6, 4'h1, 64'd0, 64'h40, 64'h40);
      apply(1'b0, 4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
      apply(1'b0, 4'h7, 4'h4, 64'd0, 64'd0, 64'd0);
      apply(1'b0, 4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
      check_val("ovf_cc_lit", {61'd0, cc}, 64'd3);
      apply(1'b0, 4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
      apply(1'b0, 4'h2, 4'h1, 64'd0, 64'h55, 64'd0);
      apply(1'b0, 4'h4, 4'h0, 64'h10, 64'd0, 64'h100);
      apply(1'b0, 4'hB, 4'h0, 64'd0, 64'h200, 64'h200);
      apply(1'b0, 4'hA, 4'h0, 64'd0, 64'd0, 64'h200);
      check_val("push_addr_lit", mem_addr, 64'h1F8);
      apply(1'b0, 4'h8, 4'h0, 64'd0, 64'd0, 64'h300);
      apply(1'b0, 4'h9, 4'h0, 64'd0, 64'h300, 64'h2F8);
      apply(1'b0, 4'h5, 4'h0, 64'h18, 64'd0, 64'h80);
      apply(1'b0, 4'h6, 4'h2, 64'd0, 64'hF0F0, 64'h0FF0);
      apply(1'b0, 4'h6, 4'h3, 64'd0, 64'hFFFF, 64'hFFFF);
      apply(1'b0, 4'h6, 4'h1, 64'd0, 64'd1, 64'h8000_0000_0000_0000);
      apply(1'b0, 4'h6, 4'h5, 64'd0, 64'd3, 64'd9);
      apply(1'b1, 4'h6, 4'h0, 64'd0, 64'd1, 64'd1);
      check_val("reset_opq_cc_lit", {61'd0, cc}, 64'd4);

      for (int i = 0; i < 40; i++) begin
         logic [3:0] ic;
         ic = 4'($urandom_range(0, 11));
         apply((($urandom_range(0, 15)) == 0), ic,
               (ic == 4'h6) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15)),
               {$urandom, $urandom}, {$urandom, $urandom},
               ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
